// File: rtl/fu_wb_resp_queue.sv
// Response buffer between the iterative divider and the writeback port.
// Holds completed uops in FIFO order while tracking branch masks and dropping squashed entries.
module fu_wb_resp_queue #(
  parameter int DEPTH  = 4,
  parameter int BR_W   = 12,
  parameter int ROB_W  = 6,
  parameter int PDST_W = 7,
  parameter int XLEN   = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_enq_valid,
  output logic                     io_enq_ready,
  input  logic [BR_W-1:0]          io_enq_br_mask,
  input  logic [ROB_W-1:0]         io_enq_rob_idx,
  input  logic [PDST_W-1:0]        io_enq_pdst,
  input  logic                     io_enq_bypassable,
  input  logic                     io_enq_is_amo,
  input  logic                     io_enq_uses_stq,
  input  logic [1:0]               io_enq_dst_rtype,
  input  logic [XLEN-1:0]          io_enq_data,
  input  logic [BR_W-1:0]          io_brupdate_resolve_mask,
  input  logic [BR_W-1:0]          io_brupdate_mispredict_mask,
  input  logic                     io_flush,
  output logic                     io_deq_valid,
  input  logic                     io_deq_ready,
  output logic [BR_W-1:0]          io_deq_br_mask,
  output logic [ROB_W-1:0]         io_deq_rob_idx,
  output logic [PDST_W-1:0]        io_deq_pdst,
  output logic                     io_deq_bypassable,
  output logic                     io_deq_is_amo,
  output logic                     io_deq_uses_stq,
  output logic [1:0]               io_deq_dst_rtype,
  output logic [XLEN-1:0]          io_deq_data,
  output logic [$clog2(DEPTH):0]   io_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DEPTH-1:0]  occ_q, occ_d;
  logic [DEPTH-1:0]  live_q, live_d;
  logic [BR_W-1:0]   br_mask_q [DEPTH];
  logic [BR_W-1:0]   br_mask_d [DEPTH];

  logic [ROB_W-1:0]  rob_q   [DEPTH];
  logic [PDST_W-1:0] pdst_q  [DEPTH];
  logic              byp_q   [DEPTH];
  logic              amo_q   [DEPTH];
  logic              stq_q   [DEPTH];
  logic [1:0]        rtype_q [DEPTH];
  logic [XLEN-1:0]   data_q  [DEPTH];

  logic enq_ready;
  logic enq_fire;
  logic enq_live;
  logic head_kill;
  logic deq_valid;
  logic pop;

  always_comb begin
    enq_ready = (count_q != CW'(DEPTH));
    enq_fire  = io_enq_valid & enq_ready;
    enq_live  = ~(io_flush | (|(io_enq_br_mask & io_brupdate_mispredict_mask)));
    head_kill = io_flush | (|(br_mask_q[head_q] & io_brupdate_mispredict_mask));
    deq_valid = occ_q[head_q] & live_q[head_q] & ~head_kill;
    // Dead heads are retired without ever reaching writeback.
    pop       = (deq_valid & io_deq_ready) | (occ_q[head_q] & ~live_q[head_q]);
  end

  always_comb begin
    occ_d   = occ_q;
    live_d  = live_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(enq_fire) - CW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      br_mask_d[i] = br_mask_q[i] & ~io_brupdate_resolve_mask;
      if (io_flush || (|(br_mask_q[i] & io_brupdate_mispredict_mask)))
        live_d[i] = 1'b0;
    end
    if (pop) begin
      occ_d[head_q]  = 1'b0;
      live_d[head_q] = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (enq_fire) begin
      occ_d[tail_q]     = 1'b1;
      live_d[tail_q]    = enq_live;
      br_mask_d[tail_q] = io_enq_br_mask & ~io_brupdate_resolve_mask;
      tail_d            = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      live_q  <= live_d;
    end
  end

  // Payload and masks carry no reset; occ/live gate every use of them.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      br_mask_q[i] <= br_mask_d[i];
    if (enq_fire) begin
      rob_q[tail_q]   <= io_enq_rob_idx;
      pdst_q[tail_q]  <= io_enq_pdst;
      byp_q[tail_q]   <= io_enq_bypassable;
      amo_q[tail_q]   <= io_enq_is_amo;
      stq_q[tail_q]   <= io_enq_uses_stq;
      rtype_q[tail_q] <= io_enq_dst_rtype;
      data_q[tail_q]  <= io_enq_data;
    end
  end

  assign io_enq_ready      = enq_ready;
  assign io_deq_valid      = deq_valid;
  assign io_deq_br_mask    = br_mask_q[head_q] & ~io_brupdate_resolve_mask;
  assign io_deq_rob_idx    = rob_q[head_q];
  assign io_deq_pdst       = pdst_q[head_q];
  assign io_deq_bypassable = byp_q[head_q];
  assign io_deq_is_amo     = amo_q[head_q];
  assign io_deq_uses_stq   = stq_q[head_q];
  assign io_deq_dst_rtype  = rtype_q[head_q];
  assign io_deq_data       = data_q[head_q];
  assign io_count          = count_q;

endmodule

// File: tb/tb_fu_wb_resp_queue.sv
// Scoreboard bench for fu_wb_resp_queue: a queue-level model predicts deliveries,
// a negedge monitor compares the DUT against them.
module tb_fu_wb_resp_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_enq_valid = 1'b0;
  logic        io_enq_ready;
  logic [11:0] io_enq_br_mask = '0;
  logic [5:0]  io_enq_rob_idx = '0;
  logic [6:0]  io_enq_pdst = '0;
  logic        io_enq_bypassable = 1'b0;
  logic        io_enq_is_amo = 1'b0;
  logic        io_enq_uses_stq = 1'b0;
  logic [1:0]  io_enq_dst_rtype = '0;
  logic [63:0] io_enq_data = '0;
  logic [11:0] io_brupdate_resolve_mask = '0;
  logic [11:0] io_brupdate_mispredict_mask = '0;
  logic        io_flush = 1'b0;
  logic        io_deq_valid;
  logic        io_deq_ready = 1'b0;
  logic [11:0] io_deq_br_mask;
  logic [5:0]  io_deq_rob_idx;
  logic [6:0]  io_deq_pdst;
  logic        io_deq_bypassable;
  logic        io_deq_is_amo;
  logic        io_deq_uses_stq;
  logic [1:0]  io_deq_dst_rtype;
  logic [63:0] io_deq_data;
  logic [2:0]  io_count;

  fu_wb_resp_queue dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
    .io_enq_br_mask(io_enq_br_mask), .io_enq_rob_idx(io_enq_rob_idx),
    .io_enq_pdst(io_enq_pdst), .io_enq_bypassable(io_enq_bypassable),
    .io_enq_is_amo(io_enq_is_amo), .io_enq_uses_stq(io_enq_uses_stq),
    .io_enq_dst_rtype(io_enq_dst_rtype), .io_enq_data(io_enq_data),
    .io_brupdate_resolve_mask(io_brupdate_resolve_mask),
    .io_brupdate_mispredict_mask(io_brupdate_mispredict_mask),
    .io_flush(io_flush),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_br_mask(io_deq_br_mask), .io_deq_rob_idx(io_deq_rob_idx),
    .io_deq_pdst(io_deq_pdst), .io_deq_bypassable(io_deq_bypassable),
    .io_deq_is_amo(io_deq_is_amo), .io_deq_uses_stq(io_deq_uses_stq),
    .io_deq_dst_rtype(io_deq_dst_rtype), .io_deq_data(io_deq_data),
    .io_count(io_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] mask;
    logic        live;
    logic [5:0]  rob;
    logic [6:0]  pdst;
    logic [4:0]  bits;   // {bypassable, is_amo, uses_stq, dst_rtype}
    logic [63:0] data;
  } ent_t;

  ent_t mdl[$];    // reference queue contents
  ent_t exp_q[$];  // deliveries the DUT owes the monitor

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int exp_count = 0;
  bit exp_enq_ready = 1'b1;
  bit exp_deq_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && reset) begin
      chk("count", 64'(io_count), 64'(exp_count));
      chk("enq_ready", 64'(io_enq_ready), 64'(exp_enq_ready));
      chk("deq_valid", 64'(io_deq_valid), 64'(exp_deq_valid));
      if (io_deq_valid && io_deq_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_deq", 64'(io_deq_rob_idx), 64'hFFFF);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          $display("deq rob=%0d pdst=%0d mask=%h data=%h", io_deq_rob_idx, io_deq_pdst, io_deq_br_mask, io_deq_data);
          chk("deq_rob", 64'(io_deq_rob_idx), 64'(e.rob));
          chk("deq_pdst", 64'(io_deq_pdst), 64'(e.pdst));
          chk("deq_bits", 64'({io_deq_bypassable, io_deq_is_amo, io_deq_uses_stq, io_deq_dst_rtype}), 64'(e.bits));
          chk("deq_data", io_deq_data, e.data);
          chk("deq_br_mask", 64'(io_deq_br_mask), 64'(e.mask));
        end
      end
    end
  end

  // One clock of stimulus; the model is advanced with the same inputs.
  task automatic drive(input bit ev, input logic [11:0] br, input logic [5:0] rob,
                       input logic [63:0] data, input logic [11:0] rs,
                       input logic [11:0] mp, input bit fl, input bit dr);
    int   n;
    bit   er, show, pop;
    ent_t e;
    logic [6:0] pd;
    logic [4:0] bt;
    pd = 7'($urandom);
    bt = 5'($urandom);
    @(posedge clock);
    #1;
    io_enq_valid = ev;
    io_enq_br_mask = br;
    io_enq_rob_idx = rob;
    io_enq_pdst = pd;
    {io_enq_bypassable, io_enq_is_amo, io_enq_uses_stq, io_enq_dst_rtype} = bt;
    io_enq_data = data;
    io_brupdate_resolve_mask = rs;
    io_brupdate_mispredict_mask = mp;
    io_flush = fl;
    io_deq_ready = dr;

    n = mdl.size();
    er = (n != DEPTH);
    show = (n > 0) && mdl[0].live && !(fl || ((mdl[0].mask & mp) != 0));
    exp_count = n;
    exp_enq_ready = er;
    exp_deq_valid = show;
    if (show && dr) begin
      e = mdl[0];
      e.mask = e.mask & ~rs;
      exp_q.push_back(e);
    end
    pop = (n > 0) && ((show && dr) || !mdl[0].live);
    for (int i = 0; i < n; i++) begin
      e = mdl[i];
      if (fl || ((e.mask & mp) != 0)) e.live = 1'b0;
      e.mask = e.mask & ~rs;
      mdl[i] = e;
    end
    if (pop) void'(mdl.pop_front());
    if (ev && er) begin
      e.mask = br & ~rs;
      e.live = !(fl || ((br & mp) != 0));
      e.rob  = rob;
      e.pdst = pd;
      e.bits = bt;
      e.data = data;
      mdl.push_back(e);
    end
  endtask

  task automatic idle(input int cycles, input bit dr);
    for (int i = 0; i < cycles; i++) drive(0, 12'h0, 6'h0, 64'h0, 12'h0, 12'h0, 0, dr);
  endtask

  task automatic rand_phase(input int cycles, input int enq_pct, input int deq_pct);
    for (int i = 0; i < cycles; i++) begin
      logic [11:0] br, rs, mp;
      br = 12'($urandom) & 12'h00F;
      rs = ($urandom_range(0, 3) == 0) ? (12'($urandom) & 12'h00F) : 12'h0;
      mp = ($urandom_range(0, 15) == 0) ? (12'h1 << $urandom_range(0, 3)) : 12'h0;
      drive($urandom_range(0, 99) < enq_pct, br, 6'($urandom),
            {$urandom, $urandom}, rs, mp, $urandom_range(0, 63) == 0,
            $urandom_range(0, 99) < deq_pct);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    chk("rst_count", 64'(io_count), 64'd0);
    chk("rst_enq_ready", 64'(io_enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(io_deq_valid), 64'd0);
    #19 reset = 1'b1;
    chk_en = 1'b1;

    // Single entry, one-cycle latency.
    drive(1, 12'h0, 6'd5, 64'hDEAD_BEEF, 12'h0, 12'h0, 0, 1);
    idle(3, 1);
    // Fill to full, extra request refused, then drain in order.
    for (int i = 1; i <= 5; i++) drive(1, 12'h0, 6'(i), 64'(i * 17), 12'h0, 12'h0, 0, 0);
    idle(6, 1);
    // Mispredict kills rob 1 and rob 3, rob 2 survives.
    drive(1, 12'h001, 6'd1, 64'h11, 12'h0, 12'h0, 0, 0);
    drive(1, 12'h002, 6'd2, 64'h22, 12'h0, 12'h0, 0, 0);
    drive(1, 12'h001, 6'd3, 64'h33, 12'h0, 12'h0, 0, 0);
    drive(0, 12'h0, 6'd0, 64'h0, 12'h0, 12'h001, 0, 1);
    idle(4, 1);
    // Resolve on the enqueue cycle protects from a later mispredict.
    drive(1, 12'h004, 6'd7, 64'h77, 12'h004, 12'h0, 0, 0);
    drive(0, 12'h0, 6'd0, 64'h0, 12'h0, 12'h004, 0, 1);
    idle(2, 1);
    // Enqueue killed in its own cycle still takes a slot briefly.
    drive(1, 12'h010, 6'd9, 64'h99, 12'h0, 12'h010, 0, 1);
    idle(3, 1);
    // Flush with three held entries.
    for (int i = 0; i < 3; i++) drive(1, 12'h0, 6'(20 + i), 64'(i), 12'h0, 12'h0, 0, 0);
    drive(0, 12'h0, 6'd0, 64'h0, 12'h0, 12'h0, 1, 1);
    idle(4, 1);

    rand_phase(1500, 60, 50);
    rand_phase(1000, 90, 20);

    // Asynchronous reset in the middle of traffic.
    @(posedge clock);
    #1;
    chk_en = 1'b0;
    io_enq_valid = 1'b0;
    io_deq_ready = 1'b0;
    io_flush = 1'b0;
    io_brupdate_resolve_mask = '0;
    io_brupdate_mispredict_mask = '0;
    reset = 1'b0;
    #1;
    chk("midrst_count", 64'(io_count), 64'd0);
    chk("midrst_deq_valid", 64'(io_deq_valid), 64'd0);
    chk("midrst_enq_ready", 64'(io_enq_ready), 64'd1);
    mdl.delete();
    exp_q.delete();
    exp_count = 0;
    exp_enq_ready = 1'b1;
    exp_deq_valid = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    rand_phase(1500, 50, 70);
    idle(8, 1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fu_wb_resp_queue.md
Name: fu_wb_resp_queue

Overview:
- Small response buffer directly downstream of the iterative divide unit.
- Accepts completed responses (uop tag fields plus 64-bit result) over a valid/ready handshake and holds them until the writeback port grants.
- Keeps tracking each entry's branch mask while the entry waits, and drops entries squashed by branch mispredicts or a pipeline flush.
- Decouples the divider from writeback-port arbitration so the divider can retire and accept new work.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
BR_W, 12, branch-mask width
ROB_W, 6, ROB index width
PDST_W, 7, physical destination register width
XLEN, 64, result data width

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
io_enq_valid  in  1  response from the divide unit is valid
io_enq_ready  out  1  queue can accept a response this cycle
io_enq_br_mask  in  BR_W  branch mask of the incoming uop
io_enq_rob_idx  in  ROB_W  ROB index
io_enq_pdst  in  PDST_W  physical destination
io_enq_bypassable  in  1  uop field, carried unchanged
io_enq_is_amo  in  1  uop field, carried unchanged
io_enq_uses_stq  in  1  uop field, carried unchanged
io_enq_dst_rtype  in  2  uop field, carried unchanged
io_enq_data  in  XLEN  result data
io_brupdate_resolve_mask  in  BR_W  branches resolved this cycle
io_brupdate_mispredict_mask  in  BR_W  branches mispredicted this cycle
io_flush  in  1  kill all entries, including any enqueue in the same cycle
io_deq_valid  out  1  head entry is presented to writeback
io_deq_ready  in  1  writeback accepts the head entry
io_deq_br_mask  out  BR_W  head branch mask, already cleared of this cycle's resolve mask
io_deq_rob_idx, io_deq_pdst, io_deq_bypassable, io_deq_is_amo, io_deq_uses_stq, io_deq_dst_rtype, io_deq_data  out  (widths as enq)  head entry fields
io_count  out  $clog2(DEPTH)+1  number of occupied slots

Behaviour:
- Storage: circular buffer with head pointer, tail pointer and count. Each slot has occ (slot in use) and live (not killed).
- Reset (asynchronous, reset low): head=0, tail=0, count=0, all occ=0 and live=0. Therefore io_deq_valid=0, io_enq_ready=1, io_count=0. Payload registers are not reset.
- io_enq_ready = (count != DEPTH). No dependence on io_deq_ready; a full queue never accepts, even if the head dequeues in the same cycle.
- Enqueue fire = io_enq_valid & io_enq_ready. It writes the slot at tail, sets occ=1 and increments tail (wrapping modulo DEPTH).
  - Stored br_mask = io_enq_br_mask & ~io_brupdate_resolve_mask.
  - live = !(io_flush | |(io_enq_br_mask & io_brupdate_mispredict_mask)).
- Every cycle, for each occ slot:
  - br_mask <= br_mask & ~resolve_mask.
  - live cleared if |(br_mask & mispredict_mask) or io_flush.
  - A killed slot keeps occ=1 until it reaches the head.
- Head outputs:
  - kill_now = io_flush | |(head.br_mask & mispredict_mask).
  - io_deq_valid = occ[head] & live[head] & ~kill_now.
  - io_deq_br_mask = head.br_mask & ~resolve_mask.
  - All other head fields are driven straight from storage.
- Pop occurs when (io_deq_valid & io_deq_ready) or (occ[head] & ~live[head]).
  - A pop clears occ and live at head and increments head (wrapping).
  - A dead head is drained one per cycle and never shown on io_deq.
- count <= count + enq_fire - pop. Simultaneous enqueue and pop leaves count unchanged.
- Latency: minimum 1 cycle from enqueue to io_deq_valid. No combinational flow-through when empty.
- Order: strict FIFO; killed entries never reorder the survivors.
- Flush: all live bits clear in one cycle. The occupied slots then drain over count cycles, and io_enq_ready stays governed by count during that drain.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight entries are lost.

Test Plan:
- Reset then enqueue rob_idx=5, data=0xDEAD_BEEF, br_mask=0, with io_deq_ready=1 -> io_deq_valid rises exactly 1 cycle later with rob_idx=5 and data=0xDEADBEEF. io_count goes 0→1→0.
- Enqueue 4 entries (rob 1..4) with io_deq_ready=0 -> io_count=4 and io_enq_ready=0. A 5th io_enq_valid is not accepted. With deq_ready=1, entries appear in order 1,2,3,4 on consecutive cycles.
- Entries with br_mask 0x001 (rob 1), 0x002 (rob 2) and 0x001 (rob 3) held, then mispredict_mask=0x001 -> io_deq_valid=0 that same cycle while rob 1 is head. Dead rob 1 drains the next cycle; rob 2 is output, then rob 3 drains silently. Final io_count=0.
- Entry br_mask=0x004, resolve_mask=0x004 on the enqueue cycle, then mispredict_mask=0x004 -> stored mask is 0, the entry survives, and io_deq_br_mask=0.
- Enqueue with br_mask=0x010 and mispredict_mask=0x010 in the same cycle -> slot consumed (io_count=1), the entry never appears on io_deq, and io_count returns to 0 after 1 cycle.
- Queue holding 3 entries, io_flush pulse -> io_deq_valid=0 from the flush cycle and io_count drops 3→2→1→0. Asserting reset low mid-operation -> io_count=0 and io_deq_valid=0 without waiting for a clock edge.
